// File: rtl/branch_pred_if.sv
// Branch predictor port bundle: fetch lookup, execute-stage update, table clear, statistics.
// Combinational lookup; updates and clear take effect at the next clock edge.
// No handshake: the predictor accepts one update per cycle and never stalls.
interface branch_pred_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   PCF;
    logic              PredTakenF;
    logic              UpdValid;
    logic [XLEN-1:0]   UpdPC;
    logic              UpdTaken;
    logic              UpdPredTaken;
    logic              Clear;
    logic [STAT_W-1:0] BranchCount;
    logic [STAT_W-1:0] MispredCount;

    modport master (
        output PCF, UpdValid, UpdPC, UpdTaken, UpdPredTaken, Clear,
        input  PredTakenF, BranchCount, MispredCount
    );

    modport slave (
        input  PCF, UpdValid, UpdPC, UpdTaken, UpdPredTaken, Clear,
        output PredTakenF, BranchCount, MispredCount
    );
endinterface

// File: rtl/branch_pred.sv
// Saturating-counter direction predictor with misprediction statistics; BRANCH_PRED_GSHARE_EN selects gshare indexing.
// Latency: prediction is combinational from PCF; table/statistics updates visible one cycle after UpdValid.
// Backpressure: none; one resolved branch accepted every cycle, the fetch pipeline is never stalled.
module branch_pred #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input logic          clk,
    input logic          rst,
    branch_pred_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  WEAK_NT  = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    logic [CTR_W-1:0]  ctrTable [ENTRIES];
    logic [IDX_W-1:0]  lookIdx;
    logic [IDX_W-1:0]  updIdx;
    logic [CTR_W-1:0]  updCur;
    logic [CTR_W-1:0]  updNext;
    logic [STAT_W-1:0] branchCnt;
    logic [STAT_W-1:0] mispredCnt;
    logic              unusedPcBits;

    // Only the word-aligned index bits of either PC select a counter.
    assign unusedPcBits = ^{bp.PCF[XLEN-1:IDX_W+2], bp.PCF[1:0],
                            bp.UpdPC[XLEN-1:IDX_W+2], bp.UpdPC[1:0]};

`ifdef BRANCH_PRED_GSHARE_EN
    logic [IDX_W-1:0] histQ;

    // Non-speculative history: only resolved branches shift in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            histQ <= '0;
        end else if (bp.Clear) begin
            histQ <= '0;
        end else if (bp.UpdValid) begin
            histQ <= {histQ[IDX_W-2:0], bp.UpdTaken};
        end
    end

    assign lookIdx = bp.PCF[IDX_W+1:2] ^ histQ;
    assign updIdx  = bp.UpdPC[IDX_W+1:2] ^ histQ;
`else
    assign lookIdx = bp.PCF[IDX_W+1:2];
    assign updIdx  = bp.UpdPC[IDX_W+1:2];
`endif

    assign bp.PredTakenF = ctrTable[lookIdx][CTR_W-1];
    assign updCur        = ctrTable[updIdx];

    always_comb begin
        updNext = updCur;
        if (bp.UpdTaken) begin
            if (updCur != CTR_MAX) updNext = updCur + 1'b1;
        end else begin
            if (updCur != '0) updNext = updCur - 1'b1;
        end
    end

    // Clear outranks a same-cycle update so a context switch never inherits stale state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) ctrTable[i] <= WEAK_NT;
        end else if (bp.Clear) begin
            for (int i = 0; i < ENTRIES; i++) ctrTable[i] <= WEAK_NT;
        end else if (bp.UpdValid) begin
            ctrTable[updIdx] <= updNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCnt  <= '0;
            mispredCnt <= '0;
        end else if (bp.UpdValid) begin
            if (branchCnt != STAT_MAX) branchCnt <= branchCnt + 1'b1;
            if ((bp.UpdTaken != bp.UpdPredTaken) && (mispredCnt != STAT_MAX))
                mispredCnt <= mispredCnt + 1'b1;
        end
    end

    assign bp.BranchCount  = branchCnt;
    assign bp.MispredCount = mispredCnt;
endmodule

// File: tb/tb_branch_pred.sv
// Directed-vector bench for branch_pred: reset, saturation, aliasing, same-cycle ordering, clear, statistics.
module tb_branch_pred;
    logic clk = 1'b0;
    logic rst;
    logic p;
    int   nChecks = 0;
    int   nPass   = 0;
    int   expBc   = 0;
    int   expMc   = 0;

    branch_pred_if #(.XLEN(32), .STAT_W(32)) bpIf ();
    branch_pred_if #(.XLEN(32), .STAT_W(4))  smIf ();

    branch_pred #(.XLEN(32), .ENTRIES(64), .CTR_W(2), .STAT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpIf)
    );

    branch_pred #(.XLEN(32), .ENTRIES(64), .CTR_W(2), .STAT_W(4)) dutSmall (
        .clk (clk),
        .rst (rst),
        .bp  (smIf)
    );

    always #5 clk = ~clk;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] pc, output logic pred);
        bpIf.PCF = pc;
        #1;
        pred = bpIf.PredTakenF;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic predTaken);
        bpIf.UpdValid     = 1'b1;
        bpIf.UpdPC        = pc;
        bpIf.UpdTaken     = taken;
        bpIf.UpdPredTaken = predTaken;
        tick();
        bpIf.UpdValid = 1'b0;
        expBc++;
        if (taken != predTaken) expMc++;
    endtask

    initial begin
        rst = 1'b0;
        bpIf.PCF = 32'h100; bpIf.UpdValid = 1'b0; bpIf.UpdPC = '0;
        bpIf.UpdTaken = 1'b0; bpIf.UpdPredTaken = 1'b0; bpIf.Clear = 1'b0;
        smIf.PCF = '0; smIf.UpdValid = 1'b0; smIf.UpdPC = '0;
        smIf.UpdTaken = 1'b0; smIf.UpdPredTaken = 1'b0; smIf.Clear = 1'b0;
        #2;
        expectEq("rst_pred", {31'b0, bpIf.PredTakenF}, 0);
        expectEq("rst_bc", bpIf.BranchCount, 0);
        expectEq("rst_mc", bpIf.MispredCount, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        peek(32'h100, p);
        expectEq("post_rst_pred", {31'b0, p}, 0);

`ifdef BRANCH_PRED_GSHARE_EN
        // history=1 after one taken update; 0x104 (index 1) now maps onto index 0
        upd(32'h100, 1'b1, 1'b0);
        peek(32'h104, p);
        expectEq("gs_look_0x104", {31'b0, p}, 1);
        peek(32'h100, p);
        expectEq("gs_look_0x100", {31'b0, p}, 0);
        upd(32'h104, 1'b1, 1'b1);
        peek(32'h108, p);
        expectEq("gs_idx1_untouched", {31'b0, p}, 0);
        peek(32'h10C, p);
        expectEq("gs_idx0_sat", {31'b0, p}, 1);
`else
        upd(32'h100, 1'b1, 1'b0);
        upd(32'h100, 1'b1, 1'b0);
        peek(32'h100, p);
        expectEq("taken2_pred", {31'b0, p}, 1);
        expectEq("taken2_bc", bpIf.BranchCount, 2);
        expectEq("taken2_mc", bpIf.MispredCount, 2);
        upd(32'h100, 1'b1, 1'b1);
        expectEq("taken3_mc", bpIf.MispredCount, 2);

        bpIf.UpdPC = 32'h100;
        bpIf.UpdTaken = 1'b0;
        repeat (3) tick();
        peek(32'h100, p);
        expectEq("hold_pred", {31'b0, p}, 1);
        expectEq("hold_bc", bpIf.BranchCount, 3);

        // from saturated 3: 2,1,0,0
        upd(32'h100, 1'b0, 1'b1);
        peek(32'h100, p);
        expectEq("nt1_pred", {31'b0, p}, 1);
        upd(32'h100, 1'b0, 1'b1);
        peek(32'h100, p);
        expectEq("nt2_pred", {31'b0, p}, 0);
        upd(32'h100, 1'b0, 1'b1);
        peek(32'h100, p);
        expectEq("nt3_pred", {31'b0, p}, 0);
        upd(32'h100, 1'b0, 1'b1);
        peek(32'h100, p);
        expectEq("nt4_pred", {31'b0, p}, 0);
        upd(32'h100, 1'b1, 1'b0);
        peek(32'h100, p);
        expectEq("floor_up1", {31'b0, p}, 0);
        upd(32'h100, 1'b1, 1'b0);
        peek(32'h100, p);
        expectEq("floor_up2", {31'b0, p}, 1);
        expectEq("mid_bc", bpIf.BranchCount, expBc);
        expectEq("mid_mc", bpIf.MispredCount, expMc);

        bpIf.Clear = 1'b1;
        tick();
        bpIf.Clear = 1'b0;
        peek(32'h100, p);
        expectEq("clr_pred", {31'b0, p}, 0);
        expectEq("clr_bc", bpIf.BranchCount, expBc);

        upd(32'h100, 1'b1, 1'b0);
        upd(32'h100, 1'b1, 1'b0);
        peek(32'h200, p);
        expectEq("alias_0x200", {31'b0, p}, 1);
        peek(32'h104, p);
        expectEq("alias_0x104", {31'b0, p}, 0);

        bpIf.Clear = 1'b1;
        tick();
        bpIf.Clear = 1'b0;
        bpIf.PCF = 32'h100;
        bpIf.UpdValid = 1'b1; bpIf.UpdPC = 32'h100;
        bpIf.UpdTaken = 1'b1; bpIf.UpdPredTaken = 1'b0;
        #1;
        expectEq("same_cyc_pre", {31'b0, bpIf.PredTakenF}, 0);
        tick();
        bpIf.UpdValid = 1'b0;
        expBc++; expMc++;
        peek(32'h100, p);
        expectEq("same_cyc_post", {31'b0, p}, 1);

        bpIf.Clear = 1'b1;
        bpIf.UpdValid = 1'b1; bpIf.UpdPC = 32'h100;
        bpIf.UpdTaken = 1'b1; bpIf.UpdPredTaken = 1'b0;
        tick();
        bpIf.Clear = 1'b0;
        bpIf.UpdValid = 1'b0;
        expBc++; expMc++;
        peek(32'h100, p);
        expectEq("clr_upd_pred", {31'b0, p}, 0);
        expectEq("clr_upd_bc", bpIf.BranchCount, expBc);
        expectEq("clr_upd_mc", bpIf.MispredCount, expMc);
`endif

        for (int i = 0; i < 20; i++) begin
            smIf.UpdValid = 1'b1; smIf.UpdPC = 32'h100;
            smIf.UpdTaken = 1'b1; smIf.UpdPredTaken = 1'b0;
            tick();
        end
        smIf.UpdValid = 1'b0;
        expectEq("stat4_bc", {28'b0, smIf.BranchCount}, 15);
        expectEq("stat4_mc", {28'b0, smIf.MispredCount}, 15);

        // asynchronous reset mid-cycle while an update is pending
        bpIf.UpdValid = 1'b1; bpIf.UpdPC = 32'h104;
        bpIf.UpdTaken = 1'b1; bpIf.UpdPredTaken = 1'b0;
        #2 rst = 1'b0;
        #1;
        expectEq("arst_bc", bpIf.BranchCount, 0);
        expectEq("arst_mc", bpIf.MispredCount, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        bpIf.UpdValid = 1'b0;
        peek(32'h104, p);
        expectEq("arst_pred", {31'b0, p}, 0);
        expectEq("arst_upd_dropped", bpIf.BranchCount, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
